// File: rtl/aes_enc_pkg.sv
// Shared types, constants and round-function helpers for the iterative
// AES-128 encryption core.
package aes_enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    // AES-128 is the only key size this core implements.
    localparam int NR_AES128 = 10;

    // Round constant for rounds 1..10; unused indices return zero.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; byte a0 sits in the top bits.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]),  mix_column(s[31:0])};
    endfunction

    // State byte i = 4*col + row lives at [127-8i -: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] =
                    s[127 - 8 * (4 * ((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    // RotWord: cyclic left rotation of a key word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Next round key from the current one; sub_rot is SubWord(RotWord(w3)).
    function automatic logic [127:0] key_expand_step(input logic [127:0] rk,
                                                     input logic [31:0]  sub_rot,
                                                     input logic [7:0]   rc);
        logic [31:0] temp, w0, w1, w2, w3;
        temp = sub_rot ^ {rc, 24'h000000};
        w0   = rk[127:96] ^ temp;
        w1   = rk[95:64]  ^ w0;
        w2   = rk[63:32]  ^ w1;
        w3   = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_encrypt_sbox.sv
// Combinational forward AES S-box: one byte in, substituted byte out.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    // Full 256-entry forward substitution table.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves subst unassigned (no latch).
        subst = 8'h00;
        case (value)
            8'h00: subst = 8'h63; 8'h01: subst = 8'h7c; 8'h02: subst = 8'h77; 8'h03: subst = 8'h7b; 8'h04: subst = 8'hf2; 8'h05: subst = 8'h6b; 8'h06: subst = 8'h6f; 8'h07: subst = 8'hc5;
            8'h08: subst = 8'h30; 8'h09: subst = 8'h01; 8'h0a: subst = 8'h67; 8'h0b: subst = 8'h2b; 8'h0c: subst = 8'hfe; 8'h0d: subst = 8'hd7; 8'h0e: subst = 8'hab; 8'h0f: subst = 8'h76;
            8'h10: subst = 8'hca; 8'h11: subst = 8'h82; 8'h12: subst = 8'hc9; 8'h13: subst = 8'h7d; 8'h14: subst = 8'hfa; 8'h15: subst = 8'h59; 8'h16: subst = 8'h47; 8'h17: subst = 8'hf0;
            8'h18: subst = 8'had; 8'h19: subst = 8'hd4; 8'h1a: subst = 8'ha2; 8'h1b: subst = 8'haf; 8'h1c: subst = 8'h9c; 8'h1d: subst = 8'ha4; 8'h1e: subst = 8'h72; 8'h1f: subst = 8'hc0;
            8'h20: subst = 8'hb7; 8'h21: subst = 8'hfd; 8'h22: subst = 8'h93; 8'h23: subst = 8'h26; 8'h24: subst = 8'h36; 8'h25: subst = 8'h3f; 8'h26: subst = 8'hf7; 8'h27: subst = 8'hcc;
            8'h28: subst = 8'h34; 8'h29: subst = 8'ha5; 8'h2a: subst = 8'he5; 8'h2b: subst = 8'hf1; 8'h2c: subst = 8'h71; 8'h2d: subst = 8'hd8; 8'h2e: subst = 8'h31; 8'h2f: subst = 8'h15;
            8'h30: subst = 8'h04; 8'h31: subst = 8'hc7; 8'h32: subst = 8'h23; 8'h33: subst = 8'hc3; 8'h34: subst = 8'h18; 8'h35: subst = 8'h96; 8'h36: subst = 8'h05; 8'h37: subst = 8'h9a;
            8'h38: subst = 8'h07; 8'h39: subst = 8'h12; 8'h3a: subst = 8'h80; 8'h3b: subst = 8'he2; 8'h3c: subst = 8'heb; 8'h3d: subst = 8'h27; 8'h3e: subst = 8'hb2; 8'h3f: subst = 8'h75;
            8'h40: subst = 8'h09; 8'h41: subst = 8'h83; 8'h42: subst = 8'h2c; 8'h43: subst = 8'h1a; 8'h44: subst = 8'h1b; 8'h45: subst = 8'h6e; 8'h46: subst = 8'h5a; 8'h47: subst = 8'ha0;
            8'h48: subst = 8'h52; 8'h49: subst = 8'h3b; 8'h4a: subst = 8'hd6; 8'h4b: subst = 8'hb3; 8'h4c: subst = 8'h29; 8'h4d: subst = 8'he3; 8'h4e: subst = 8'h2f; 8'h4f: subst = 8'h84;
            8'h50: subst = 8'h53; 8'h51: subst = 8'hd1; 8'h52: subst = 8'h00; 8'h53: subst = 8'hed; 8'h54: subst = 8'h20; 8'h55: subst = 8'hfc; 8'h56: subst = 8'hb1; 8'h57: subst = 8'h5b;
            8'h58: subst = 8'h6a; 8'h59: subst = 8'hcb; 8'h5a: subst = 8'hbe; 8'h5b: subst = 8'h39; 8'h5c: subst = 8'h4a; 8'h5d: subst = 8'h4c; 8'h5e: subst = 8'h58; 8'h5f: subst = 8'hcf;
            8'h60: subst = 8'hd0; 8'h61: subst = 8'hef; 8'h62: subst = 8'haa; 8'h63: subst = 8'hfb; 8'h64: subst = 8'h43; 8'h65: subst = 8'h4d; 8'h66: subst = 8'h33; 8'h67: subst = 8'h85;
            8'h68: subst = 8'h45; 8'h69: subst = 8'hf9; 8'h6a: subst = 8'h02; 8'h6b: subst = 8'h7f; 8'h6c: subst = 8'h50; 8'h6d: subst = 8'h3c; 8'h6e: subst = 8'h9f; 8'h6f: subst = 8'ha8;
            8'h70: subst = 8'h51; 8'h71: subst = 8'ha3; 8'h72: subst = 8'h40; 8'h73: subst = 8'h8f; 8'h74: subst = 8'h92; 8'h75: subst = 8'h9d; 8'h76: subst = 8'h38; 8'h77: subst = 8'hf5;
            8'h78: subst = 8'hbc; 8'h79: subst = 8'hb6; 8'h7a: subst = 8'hda; 8'h7b: subst = 8'h21; 8'h7c: subst = 8'h10; 8'h7d: subst = 8'hff; 8'h7e: subst = 8'hf3; 8'h7f: subst = 8'hd2;
            8'h80: subst = 8'hcd; 8'h81: subst = 8'h0c; 8'h82: subst = 8'h13; 8'h83: subst = 8'hec; 8'h84: subst = 8'h5f; 8'h85: subst = 8'h97; 8'h86: subst = 8'h44; 8'h87: subst = 8'h17;
            8'h88: subst = 8'hc4; 8'h89: subst = 8'ha7; 8'h8a: subst = 8'h7e; 8'h8b: subst = 8'h3d; 8'h8c: subst = 8'h64; 8'h8d: subst = 8'h5d; 8'h8e: subst = 8'h19; 8'h8f: subst = 8'h73;
            8'h90: subst = 8'h60; 8'h91: subst = 8'h81; 8'h92: subst = 8'h4f; 8'h93: subst = 8'hdc; 8'h94: subst = 8'h22; 8'h95: subst = 8'h2a; 8'h96: subst = 8'h90; 8'h97: subst = 8'h88;
            8'h98: subst = 8'h46; 8'h99: subst = 8'hee; 8'h9a: subst = 8'hb8; 8'h9b: subst = 8'h14; 8'h9c: subst = 8'hde; 8'h9d: subst = 8'h5e; 8'h9e: subst = 8'h0b; 8'h9f: subst = 8'hdb;
            8'ha0: subst = 8'he0; 8'ha1: subst = 8'h32; 8'ha2: subst = 8'h3a; 8'ha3: subst = 8'h0a; 8'ha4: subst = 8'h49; 8'ha5: subst = 8'h06; 8'ha6: subst = 8'h24; 8'ha7: subst = 8'h5c;
            8'ha8: subst = 8'hc2; 8'ha9: subst = 8'hd3; 8'haa: subst = 8'hac; 8'hab: subst = 8'h62; 8'hac: subst = 8'h91; 8'had: subst = 8'h95; 8'hae: subst = 8'he4; 8'haf: subst = 8'h79;
            8'hb0: subst = 8'he7; 8'hb1: subst = 8'hc8; 8'hb2: subst = 8'h37; 8'hb3: subst = 8'h6d; 8'hb4: subst = 8'h8d; 8'hb5: subst = 8'hd5; 8'hb6: subst = 8'h4e; 8'hb7: subst = 8'ha9;
            8'hb8: subst = 8'h6c; 8'hb9: subst = 8'h56; 8'hba: subst = 8'hf4; 8'hbb: subst = 8'hea; 8'hbc: subst = 8'h65; 8'hbd: subst = 8'h7a; 8'hbe: subst = 8'hae; 8'hbf: subst = 8'h08;
            8'hc0: subst = 8'hba; 8'hc1: subst = 8'h78; 8'hc2: subst = 8'h25; 8'hc3: subst = 8'h2e; 8'hc4: subst = 8'h1c; 8'hc5: subst = 8'ha6; 8'hc6: subst = 8'hb4; 8'hc7: subst = 8'hc6;
            8'hc8: subst = 8'he8; 8'hc9: subst = 8'hdd; 8'hca: subst = 8'h74; 8'hcb: subst = 8'h1f; 8'hcc: subst = 8'h4b; 8'hcd: subst = 8'hbd; 8'hce: subst = 8'h8b; 8'hcf: subst = 8'h8a;
            8'hd0: subst = 8'h70; 8'hd1: subst = 8'h3e; 8'hd2: subst = 8'hb5; 8'hd3: subst = 8'h66; 8'hd4: subst = 8'h48; 8'hd5: subst = 8'h03; 8'hd6: subst = 8'hf6; 8'hd7: subst = 8'h0e;
            8'hd8: subst = 8'h61; 8'hd9: subst = 8'h35; 8'hda: subst = 8'h57; 8'hdb: subst = 8'hb9; 8'hdc: subst = 8'h86; 8'hdd: subst = 8'hc1; 8'hde: subst = 8'h1d; 8'hdf: subst = 8'h9e;
            8'he0: subst = 8'he1; 8'he1: subst = 8'hf8; 8'he2: subst = 8'h98; 8'he3: subst = 8'h11; 8'he4: subst = 8'h69; 8'he5: subst = 8'hd9; 8'he6: subst = 8'h8e; 8'he7: subst = 8'h94;
            8'he8: subst = 8'h9b; 8'he9: subst = 8'h1e; 8'hea: subst = 8'h87; 8'heb: subst = 8'he9; 8'hec: subst = 8'hce; 8'hed: subst = 8'h55; 8'hee: subst = 8'h28; 8'hef: subst = 8'hdf;
            8'hf0: subst = 8'h8c; 8'hf1: subst = 8'ha1; 8'hf2: subst = 8'h89; 8'hf3: subst = 8'h0d; 8'hf4: subst = 8'hbf; 8'hf5: subst = 8'he6; 8'hf6: subst = 8'h42; 8'hf7: subst = 8'h68;
            8'hf8: subst = 8'h41; 8'hf9: subst = 8'h99; 8'hfa: subst = 8'h2d; 8'hfb: subst = 8'h0f; 8'hfc: subst = 8'hb0; 8'hfd: subst = 8'h54; 8'hfe: subst = 8'hbb; 8'hff: subst = 8'h16;
            default: subst = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryption core: one full round per clock, round keys
// derived on the fly from the previous round key, level START / held DONE.
module aes_encrypt
    import aes_enc_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         AES_START,
    output logic         AES_DONE,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_DEC,
    output logic [127:0] AES_MSG_ENC
);

    // The round counter, Rcon table and key schedule only cover AES-128.
    if (NR != NR_AES128) begin : g_nr_check
        $error("aes_encrypt: only NR = 10 (AES-128) is supported");
    end

    fsm_e         fsm_q;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [3:0]   round_q;
    logic         done_q;
    logic [127:0] msg_enc_q;

    logic [127:0] sub_state;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_rot;
    logic [127:0] rk_next;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] round_out;
    logic         last_round;

    // SubBytes on all sixteen state bytes.
    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        aes_sbox u_sbox (
            .value (state_q[127 - 8 * i -: 8]),
            .subst (sub_state[127 - 8 * i -: 8])
        );
    end

    // SubWord(RotWord(w3)) for the key schedule.
    assign rot_w3 = rot_word(rk_q[31:0]);

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox (
            .value (rot_w3[31 - 8 * j -: 8]),
            .subst (sub_rot[31 - 8 * j -: 8])
        );
    end

    assign rk_next    = key_expand_step(rk_q, sub_rot, rcon(round_q));
    assign shifted    = shift_rows(sub_state);
    assign mixed      = mix_columns(shifted);
    assign last_round = (round_q == 4'(NR));
    assign round_out  = (last_round ? shifted : mixed) ^ rk_next;

    // Control FSM plus state, round-key, counter and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            fsm_q     <= IDLE;
            state_q   <= '0;
            rk_q      <= '0;
            round_q   <= '0;
            done_q    <= 1'b0;
            msg_enc_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (AES_START) begin
                        state_q <= AES_MSG_DEC ^ AES_KEY;
                        rk_q    <= AES_KEY;
                        round_q <= 4'd1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    if (!AES_START) begin
                        // Abort: discard the partial state, leave the last ciphertext alone.
                        fsm_q <= IDLE;
                    end else begin
                        state_q <= round_out;
                        rk_q    <= rk_next;
                        if (last_round) begin
                            msg_enc_q <= round_out;
                            done_q    <= 1'b1;
                            fsm_q     <= DONE;
                        end else begin
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (!AES_START) begin
                        done_q <= 1'b0;
                        fsm_q  <= IDLE;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    fsm_q  <= IDLE;
                end
            endcase
        end
    end

    assign AES_DONE    = done_q;
    assign AES_MSG_ENC = msg_enc_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// Directed-vector bench for the iterative AES-128 encryption core.
module tb_aes_encrypt;
    import aes_enc_pkg::*;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] R0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_DEC;
    logic [127:0] AES_MSG_ENC;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    aes_encrypt #(.NR(10)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .AES_START   (AES_START),
        .AES_DONE    (AES_DONE),
        .AES_KEY     (AES_KEY),
        .AES_MSG_DEC (AES_MSG_DEC),
        .AES_MSG_ENC (AES_MSG_ENC)
    );

    // Raise START with the given vector and count edges after capture until DONE (0 = timeout).
    task automatic start_and_wait(input logic [127:0] key, input logic [127:0] pt, output int cycles);
        @(negedge CLK);
        AES_KEY     = key;
        AES_MSG_DEC = pt;
        AES_START   = 1'b1;
        @(posedge CLK);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            #1;
            if (AES_DONE === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Drop START and land just after the following edge.
    task automatic drop_start();
        @(negedge CLK);
        AES_START = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N     = 1'b0;
        AES_START   = 1'b0;
        AES_KEY     = '0;
        AES_MSG_DEC = '0;
        #12;
        total++;
        if (AES_DONE !== 1'b0) begin
            bad++;
            $display("FAIL reset_done: got %b expected 0", AES_DONE);
        end
        total++;
        if (AES_MSG_ENC !== 128'h0) begin
            bad++;
            $display("FAIL reset_msg: got %h expected 0", AES_MSG_ENC);
        end
        total++;
        if (dut.fsm_q !== IDLE) begin
            bad++;
            $display("FAIL reset_fsm: got %0d expected %0d", dut.fsm_q, IDLE);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_fips_b();
        int early = 0;
        @(negedge CLK);
        AES_KEY     = KEY_B;
        AES_MSG_DEC = PT_B;
        AES_START   = 1'b1;
        @(posedge CLK);
        #1;
        total++;
        if (dut.state_q !== R0_B) begin
            bad++;
            $display("FAIL b_initial_state: got %h expected %h", dut.state_q, R0_B);
        end
        @(posedge CLK);
        #1;
        total++;
        if (dut.state_q !== R1_B) begin
            bad++;
            $display("FAIL b_round1_state: got %h expected %h", dut.state_q, R1_B);
        end
        if (AES_DONE !== 1'b0) early++;
        for (int k = 2; k <= 10; k++) begin
            @(posedge CLK);
            #1;
            if (k < 10 && AES_DONE !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL b_done_early: got %0d early cycles expected 0", early);
        end
        total++;
        if (AES_DONE !== 1'b1) begin
            bad++;
            $display("FAIL b_done_latency: got %b at edge +10 expected 1", AES_DONE);
        end
        total++;
        if (AES_MSG_ENC !== CT_B) begin
            bad++;
            $display("FAIL b_ciphertext: got %h expected %h", AES_MSG_ENC, CT_B);
        end
        drop_start();
        total++;
        if (AES_DONE !== 1'b0) begin
            bad++;
            $display("FAIL b_done_fall: got %b expected 0", AES_DONE);
        end
    endtask

    task automatic test_fips_c1();
        int cycles;
        start_and_wait(KEY_C, PT_C, cycles);
        total++;
        if (cycles != 10) begin
            bad++;
            $display("FAIL c1_latency: got %0d expected 10", cycles);
        end
        total++;
        if (AES_MSG_ENC !== CT_C) begin
            bad++;
            $display("FAIL c1_ciphertext: got %h expected %h", AES_MSG_ENC, CT_C);
        end
        drop_start();
        total++;
        if (AES_DONE !== 1'b0) begin
            bad++;
            $display("FAIL c1_done_fall: got %b expected 0", AES_DONE);
        end
    endtask

    task automatic test_abort();
        int stray = 0;
        @(negedge CLK);
        AES_KEY     = KEY_B;
        AES_MSG_DEC = PT_B;
        AES_START   = 1'b1;
        @(posedge CLK);
        repeat (5) @(posedge CLK);
        drop_start();
        total++;
        if (dut.fsm_q !== IDLE) begin
            bad++;
            $display("FAIL abort_fsm: got %0d expected %0d", dut.fsm_q, IDLE);
        end
        total++;
        if (AES_MSG_ENC !== CT_C) begin
            bad++;
            $display("FAIL abort_msg_kept: got %h expected %h", AES_MSG_ENC, CT_C);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (AES_DONE !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL abort_done_low: got %0d high cycles expected 0", stray);
        end
    endtask

    task automatic test_input_stability();
        int cycles = 0;
        @(negedge CLK);
        AES_KEY     = KEY_B;
        AES_MSG_DEC = PT_B;
        AES_START   = 1'b1;
        @(posedge CLK);
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            AES_KEY     = {$urandom, $urandom, $urandom, $urandom};
            AES_MSG_DEC = {$urandom, $urandom, $urandom, $urandom};
            @(posedge CLK);
            #1;
            if (AES_DONE === 1'b1) begin
                cycles = i;
                break;
            end
        end
        total++;
        if (cycles != 10) begin
            bad++;
            $display("FAIL stable_latency: got %0d expected 10", cycles);
        end
        total++;
        if (AES_MSG_ENC !== CT_B) begin
            bad++;
            $display("FAIL stable_ciphertext: got %h expected %h", AES_MSG_ENC, CT_B);
        end
        drop_start();
        total++;
        if (AES_DONE !== 1'b0) begin
            bad++;
            $display("FAIL stable_done_fall: got %b expected 0", AES_DONE);
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        AES_KEY     = KEY_C;
        AES_MSG_DEC = PT_C;
        AES_START   = 1'b1;
        @(posedge CLK);
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (AES_MSG_ENC !== CT_B) begin
            bad++;
            $display("FAIL areset_pre_msg: got %h expected %h", AES_MSG_ENC, CT_B);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        total++;
        if (AES_MSG_ENC !== 128'h0) begin
            bad++;
            $display("FAIL areset_msg: got %h expected 0", AES_MSG_ENC);
        end
        total++;
        if (AES_DONE !== 1'b0) begin
            bad++;
            $display("FAIL areset_done: got %b expected 0", AES_DONE);
        end
        total++;
        if (dut.fsm_q !== IDLE || dut.state_q !== 128'h0 || dut.round_q !== 4'd0) begin
            bad++;
            $display("FAIL areset_internal: got fsm=%0d state=%h round=%0d expected IDLE/0/0",
                     dut.fsm_q, dut.state_q, dut.round_q);
        end
        AES_START = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_hold_start();
        int cycles;
        int slips = 0;
        start_and_wait(KEY_B, PT_B, cycles);
        total++;
        if (cycles != 10 || AES_MSG_ENC !== CT_B) begin
            bad++;
            $display("FAIL hold_first_op: got %0d cycles ct %h expected 10 cycles ct %h", cycles, AES_MSG_ENC, CT_B);
        end
        @(negedge CLK);
        AES_KEY     = KEY_C;
        AES_MSG_DEC = PT_C;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK);
            #1;
            if (AES_DONE !== 1'b1 || AES_MSG_ENC !== CT_B || dut.fsm_q !== DONE) slips++;
        end
        total++;
        if (slips != 0) begin
            bad++;
            $display("FAIL hold_done_stable: got %0d bad cycles expected 0", slips);
        end
    endtask

    task automatic test_back_to_back();
        int cycles = 0;
        int held_bad = 0;
        drop_start();
        total++;
        if (AES_DONE !== 1'b0 || dut.fsm_q !== IDLE) begin
            bad++;
            $display("FAIL b2b_gap: got done=%b fsm=%0d expected done=0 fsm=IDLE", AES_DONE, dut.fsm_q);
        end
        @(negedge CLK);
        AES_START = 1'b1;
        @(posedge CLK);
        #1;
        if (AES_DONE !== 1'b0) held_bad++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            #1;
            if (AES_DONE === 1'b1) begin
                cycles = i;
                break;
            end
            if (AES_MSG_ENC !== CT_B) held_bad++;
        end
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL b2b_intervening: got %0d bad cycles expected 0", held_bad);
        end
        total++;
        if (cycles != 10) begin
            bad++;
            $display("FAIL b2b_latency: got %0d expected 10", cycles);
        end
        total++;
        if (AES_MSG_ENC !== CT_C) begin
            bad++;
            $display("FAIL b2b_ciphertext: got %h expected %h", AES_MSG_ENC, CT_C);
        end
        drop_start();
        total++;
        if (AES_DONE !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_fall: got %b expected 0", AES_DONE);
        end
    endtask

    initial begin
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_abort();
        test_input_stability();
        test_async_reset();
        test_hold_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
